multicycle_control: RTL and testbench

Sequencing controller for the multi-cycle MIPS-subset datapath: a Moore FSM, with memory-handshake qualification, that steps each instruction through fetch, decode, execute, memory and write-back. It drives the shared-memory, IR, PC, ALU-mux and register-file enables each cycle. Supported opcodes are R-type (0), LW (35), SW (43), BEQ (4), ADDI (8) and J (2). It stalls on a single `mem_ready` handshake from the unified instruction/data memory.

---
 rtl/multicycle_control.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: sequencing FSM for a multi-cycle MIPS-subset datapath.
// It walks each instruction through fetch, decode, execute, memory and
// write-back, stalling FETCH, MEM_READ and MEM_WRITE on mem_ready.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_J     = 6'd2;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BEQ       = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;

  state_e state_q, state_d;
  // run_q is low from reset until the first rising edge after rst_n releases;
  // it holds every output at 0 until then so the first FETCH cycle begins
  // on that edge, and reset assertion kills all enables immediately.
  logic   run_q, run_d;

  // State register and run flag.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Next-state logic.
  // NOTE: every variable gets a default at the top of each always_comb so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    run_d   = 1'b1;
    if (!run_q) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:     if (mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
            OP_RTYPE:     state_d = S_R_EXEC;
            OP_BEQ:       state_d = S_BEQ;
            OP_J:         state_d = S_JUMP;
            OP_ADDI:      state_d = S_ADDI_EXEC;
            default:      state_d = S_FETCH;
          endcase
        end
        S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
        S_MEM_WB:    state_d = S_FETCH;
        S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
        S_R_EXEC:    state_d = S_R_WB;
        S_R_WB:      state_d = S_FETCH;
        S_BEQ:       state_d = S_FETCH;
        S_JUMP:      state_d = S_FETCH;
        S_ADDI_EXEC: state_d = S_ADDI_WB;
        S_ADDI_WB:   state_d = S_FETCH;
        default:     state_d = S_FETCH;
      endcase
    end
  end

  // Datapath enables/selects decoded from the current state.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          if (!(opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J})) begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_R_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_R_WB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        S_ADDI_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_ADDI_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: random instruction streams with
// random wait states, checked cycle by cycle against an expected trace built
// from the instruction-level behaviour, plus reset and mid-write reset cases.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       instr_done, illegal_op;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .IRWrite    (IRWrite),
    .ALUSrcA    (ALUSrcA),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource),
    .state      (state),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, memto_reg;
    logic       ir_write, alu_src_a, reg_write, reg_dst;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
  } ctrl_t;

  typedef struct {
    logic [3:0] st;
    logic       mr;
    logic [5:0] op;
    ctrl_t      c;
  } step_t;

  step_t trace[$];
  int    cpi_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc_since = 0;
  ctrl_t act;

  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                IRWrite, ALUSrcA, RegWrite, RegDst, ALUSrcB, ALUOp, PCSource,
                instr_done, illegal_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic mr, input logic [5:0] op, input ctrl_t c);
    step_t e;
    e.st = st; e.mr = mr; e.op = op; e.c = c;
    trace.push_back(e);
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2};
  endfunction

  // Expected cycle-by-cycle trace of one instruction: fw FETCH waits,
  // mw memory-phase waits (LW/SW only). Also queues its total cycle count.
  task automatic build(input logic [5:0] op, input int fw, input int mw);
    ctrl_t c;
    int    base;
    for (int i = 0; i < fw; i++) begin
      c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
      push(4'd0, 1'b0, 6'($urandom), c);
    end
    c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = 1'b1; c.pc_write = 1'b1;
    push(4'd0, 1'b1, 6'($urandom), c);
    c = '0; c.alu_src_b = 2'b11;
    if (!is_legal(op)) begin c.instr_done = 1'b1; c.illegal_op = 1'b1; end
    push(4'd1, 1'($urandom), op, c);
    case (op)
      6'd35, 6'd43: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        push(4'd2, 1'($urandom), op, c);
        c = '0; c.iord = 1'b1;
        if (op == 6'd35) c.mem_read = 1'b1; else c.mem_write = 1'b1;
        for (int i = 0; i < mw; i++) push((op == 6'd35) ? 4'd3 : 4'd5, 1'b0, op, c);
        if (op == 6'd35) begin
          push(4'd3, 1'b1, op, c);
          c = '0; c.reg_write = 1'b1; c.memto_reg = 1'b1; c.instr_done = 1'b1;
          push(4'd4, 1'($urandom), op, c);
        end else begin
          c.instr_done = 1'b1;
          push(4'd5, 1'b1, op, c);
        end
      end
      6'd0: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b10;
        push(4'd6, 1'($urandom), op, c);
        c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1;
        push(4'd7, 1'($urandom), op, c);
      end
      6'd4: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
        c.pc_source = 2'b01; c.instr_done = 1'b1;
        push(4'd8, 1'($urandom), op, c);
      end
      6'd2: begin
        c = '0; c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1;
        push(4'd9, 1'($urandom), op, c);
      end
      6'd8: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        push(4'd10, 1'($urandom), op, c);
        c = '0; c.reg_write = 1'b1; c.instr_done = 1'b1;
        push(4'd11, 1'($urandom), op, c);
      end
      default: ;
    endcase
    // Zero-wait cycles per instruction class, plus one per wait cycle.
    case (op)
      6'd4, 6'd2:          base = 3;
      6'd0, 6'd43, 6'd8:   base = 4;
      6'd35:               base = 5;
      default:             base = 2;
    endcase
    cpi_q.push_back(base + fw + ((op == 6'd35 || op == 6'd43) ? mw : 0));
  endtask

  // Drive and check up to n queued cycles.
  task automatic run_trace(input int n);
    step_t e;
    int    exp_cpi;
    for (int k = 0; k < n && trace.size() > 0; k++) begin
      e = trace.pop_front();
      @(negedge clk);
      mem_ready = e.mr;
      opcode    = e.op;
      #1;
      check($sformatf("cycle st%0d op%0d", e.st, e.op), 32'({state, act}), 32'({e.st, e.c}));
      cyc_since++;
      if (instr_done) begin
        exp_cpi = (cpi_q.size() > 0) ? cpi_q.pop_front() : -1;
        check("cpi", 32'(cyc_since), 32'(exp_cpi));
        cyc_since = 0;
      end
    end
  endtask

  task automatic build_random(input int count);
    logic [5:0] legal[6] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2};
    logic [5:0] op;
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal[$urandom_range(0, 5)];
      end
      build(op, $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'd0;
    repeat (3) begin
      @(negedge clk); #1;
      check("reset_hold", 32'({state, act}), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_idle", 32'({state, act}), 32'd0);

    // Directed sequences from the instruction-level behaviour.
    build(6'd0, 0, 0);    // R-type
    build(6'd35, 0, 2);   // LW, two MEM_READ waits
    build(6'd43, 1, 0);   // SW, one FETCH wait
    build(6'd4, 0, 0);    // BEQ
    build(6'd2, 0, 0);    // J
    build(6'd63, 0, 0);   // illegal
    build_random(40);
    run_trace(100000);

    // Reset dropped during a stalled MEM_WRITE.
    build(6'd43, 0, 2);
    run_trace(4);
    #2 rst_n = 1'b0;
    #1;
    check("midwrite_memwrite", 32'(MemWrite), 32'd0);
    check("midwrite_all", 32'({state, act}), 32'd0);
    trace.delete();
    cpi_q.delete();
    cyc_since = 0;
    @(negedge clk);
    #1;
    check("midwrite_held", 32'({state, act}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("midwrite_release", 32'({state, act}), 32'd0);
    build_random(10);
    run_trace(100000);
    check("all_retired", 32'(cpi_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
